pipe_ctrl: RTL and testbench

- Sequential pipeline-control stage directly downstream of the Load-Use, Jump and Branch hazard detectors.
- Merges their per-register choice codes (00 flush, 01 load, 10 keep) into one resolved decision per pipeline register.
- Owns the PC register and the IF/ID register, and emits the resolved ID/EX choice to the ID/EX register.
- Keeps saturating stall/flush event counters and a sticky illegal-code flag.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_sat_counter.sv | 19 +
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline-control stage: hazard choice codes,
// the resolved per-cycle decision and the code-normalising helper.
package pipe_ctrl_pkg;

    localparam logic [1:0]  CH_FLUSH = 2'b00;
    localparam logic [1:0]  CH_LOAD  = 2'b01;
    localparam logic [1:0]  CH_KEEP  = 2'b10;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

    typedef enum logic [2:0] {
        DEC_LOAD,
        DEC_EXT_STALL,
        DEC_BRANCH,
        DEC_LU_STALL,
        DEC_JUMP
    } decision_t;

    // The unused encoding 2'b11 behaves as a plain load.
    function automatic logic [1:0] norm_code(input logic [1:0] code);
        return (code == 2'b11) ? CH_LOAD : code;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating event counter with synchronous active-low clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Resolves the load-use, jump and branch hazard choices into one decision
// per cycle; owns the PC and IF/ID registers and the event counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       lu_pc_choice,
    input  logic [1:0]       lu_ifid_choice,
    input  logic [1:0]       lu_idex_choice,
    input  logic [1:0]       j_ifid_choice,
    input  logic [1:0]       b_ifid_choice,
    input  logic [1:0]       b_idex_choice,
    input  logic             ext_stall,
    input  logic [31:0]      pc_next,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc_plus4,
    output logic [31:0]      pc,
    output logic [31:0]      ifid_instr,
    output logic [31:0]      ifid_pc_plus4,
    output logic             ifid_valid,
    output logic [1:0]       idex_choice,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             code_err
);

    logic      b_flush, j_flush, lu_keep, lu_flush, bad_code;
    decision_t decision;
    logic      pc_load, ifid_load, ifid_flush, stall_inc, flush_inc;

    always_comb begin
        b_flush  = (norm_code(b_ifid_choice) == CH_FLUSH) ||
                   (norm_code(b_idex_choice) == CH_FLUSH);
        j_flush  = (norm_code(j_ifid_choice) == CH_FLUSH);
        lu_keep  = (norm_code(lu_pc_choice) == CH_KEEP) ||
                   (norm_code(lu_ifid_choice) == CH_KEEP);
        lu_flush = (norm_code(lu_idex_choice) == CH_FLUSH);
        bad_code = (lu_pc_choice == 2'b11) || (lu_ifid_choice == 2'b11) ||
                   (lu_idex_choice == 2'b11) || (j_ifid_choice == 2'b11) ||
                   (b_ifid_choice == 2'b11) || (b_idex_choice == 2'b11);
    end

    // Branch beats load-use (older instruction); load-use beats jump so a jr
    // never redirects on a stale rs.
    always_comb begin
        decision = DEC_LOAD;
        if (ext_stall)    decision = DEC_EXT_STALL;
        else if (b_flush) decision = DEC_BRANCH;
        else if (lu_keep) decision = DEC_LU_STALL;
        else if (j_flush) decision = DEC_JUMP;
    end

    always_comb begin
        idex_choice = CH_LOAD;
        pc_load     = 1'b0;
        ifid_load   = 1'b0;
        ifid_flush  = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        case (decision)
            DEC_EXT_STALL: begin
                idex_choice = CH_KEEP;
                stall_inc   = 1'b1;
            end
            DEC_BRANCH: begin
                idex_choice = CH_FLUSH;
                pc_load     = 1'b1;
                ifid_flush  = 1'b1;
                flush_inc   = 1'b1;
            end
            DEC_LU_STALL: begin
                idex_choice = lu_flush ? CH_FLUSH : CH_LOAD;
                stall_inc   = 1'b1;
            end
            DEC_JUMP: begin
                pc_load    = 1'b1;
                ifid_flush = 1'b1;
                flush_inc  = 1'b1;
            end
            default: begin
                pc_load   = 1'b1;
                ifid_load = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc            <= PC_RESET;
            ifid_instr    <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
            code_err      <= 1'b0;
        end else begin
            if (pc_load) pc <= pc_next;
            if (ifid_flush) begin
                ifid_instr    <= '0;
                ifid_pc_plus4 <= '0;
                ifid_valid    <= 1'b0;
            end else if (ifid_load) begin
                ifid_instr    <= if_instr;
                ifid_pc_plus4 <= if_pc_plus4;
                ifid_valid    <= 1'b1;
            end
            if (bad_code) code_err <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed hazard scenarios followed by
// random stimulus, checked against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    lu_pc, lu_ifid, lu_idex, j_ifid, b_ifid, b_idex;
    logic          ext;
    logic [31:0]   pc_next, if_instr, if_pc_plus4;
    logic [31:0]   pc, ifid_instr, ifid_pc_plus4;
    logic          ifid_valid, code_err;
    logic [1:0]    idex_choice;
    logic [CW-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_RESET(32'h0), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset          (rst_n),
        .lu_pc_choice   (lu_pc),
        .lu_ifid_choice (lu_ifid),
        .lu_idex_choice (lu_idex),
        .j_ifid_choice  (j_ifid),
        .b_ifid_choice  (b_ifid),
        .b_idex_choice  (b_idex),
        .ext_stall      (ext),
        .pc_next        (pc_next),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4),
        .pc             (pc),
        .ifid_instr     (ifid_instr),
        .ifid_pc_plus4  (ifid_pc_plus4),
        .ifid_valid     (ifid_valid),
        .idex_choice    (idex_choice),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .code_err       (code_err)
    );

    typedef struct {
        logic [31:0] pc, instr, p4;
        logic        valid, err;
        logic [1:0]  idex;
        int          stall, flush;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid, m_err;
    int          m_stall, m_flush;

    task automatic step(input bit rst, input logic [1:0] lpc, lif, lid,
                        jif, bif, bid, input bit st, input logic [31:0] pn);
        exp_t        e;
        bit          bf, jf, luk, luf, bad;
        logic [31:0] ins, p4;
        @(negedge clk);
        ins = $urandom; p4 = $urandom;
        rst_n = ~rst; lu_pc = lpc; lu_ifid = lif; lu_idex = lid;
        j_ifid = jif; b_ifid = bif; b_idex = bid; ext = st;
        pc_next = pn; if_instr = ins; if_pc_plus4 = p4;

        bf  = (bif == 2'b00) || (bid == 2'b00);
        jf  = (jif == 2'b00);
        luk = (lpc == 2'b10) || (lif == 2'b10);
        luf = (lid == 2'b00);
        bad = (lpc == 2'b11) || (lif == 2'b11) || (lid == 2'b11) ||
              (jif == 2'b11) || (bif == 2'b11) || (bid == 2'b11);

        e.idex = st ? 2'b10 : bf ? 2'b00 : luk ? (luf ? 2'b00 : 2'b01) : 2'b01;
        if (rst) begin
            m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_err = 0;
            m_stall = 0; m_flush = 0;
        end else begin
            if (bad) m_err = 1;
            if (st || (!bf && luk)) begin
                m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
            end else begin
                m_pc = pn;
                if (bf || jf) begin
                    m_instr = 0; m_p4 = 0; m_valid = 0;
                    m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                end else begin
                    m_instr = ins; m_p4 = p4; m_valid = 1;
                end
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.p4 = m_p4; e.valid = m_valid;
        e.err = m_err; e.stall = m_stall; e.flush = m_flush;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic [31:0] pn);
        for (int i = 0; i < n; i++)
            step(0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, pn + 32'(4 * i));
    endtask

    function automatic logic [1:0] rcode(input bit allow_bad);
        int r = int'($urandom_range(0, 9));
        if (r < 2) return 2'b00;
        if (r < 4) return 2'b10;
        if (r == 9 && allow_bad) return 2'b11;
        return 2'b01;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %h expected %h", nm, vectors, got, want);
        end
    endtask

    // Monitor: every post-edge sample is one scoreboard transaction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                chk("pc",        pc,             e.pc);
                chk("ifid_instr", ifid_instr,    e.instr);
                chk("ifid_pc4",  ifid_pc_plus4,  e.p4);
                chk("ifid_valid", 32'(ifid_valid), 32'(e.valid));
                chk("idex",      32'(idex_choice), 32'(e.idex));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
                chk("flush_cnt", 32'(flush_cnt), 32'(e.flush));
                chk("code_err",  32'(code_err),  32'(e.err));
                $display("vec %0d pc=%h valid=%0b idex=%0d stall=%0d flush=%0d err=%0b",
                         vectors, pc, ifid_valid, idex_choice, stall_cnt, flush_cnt, code_err);
            end
        end
    end

    initial begin
        rst_n = 1'b0; lu_pc = 2'b01; lu_ifid = 2'b01; lu_idex = 2'b01;
        j_ifid = 2'b01; b_ifid = 2'b01; b_idex = 2'b01; ext = 1'b0;
        pc_next = 0; if_instr = 0; if_pc_plus4 = 0;
        m_pc = 0; m_instr = 0; m_p4 = 0; m_valid = 0; m_err = 0;
        m_stall = 0; m_flush = 0;

        // Reset, then release: pc follows pc_next
        step(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, 32'h10);
        step(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, 32'h10);
        idle(3, 32'h10);
        // Load-use stall with ID/EX flush
        step(0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 0, 32'h80);
        // Branch together with load-use: branch wins
        step(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, 32'h0);
        idle(2, 32'h100);
        step(0, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 0, 32'h200);
        // Jump under load-use is held, then taken on release
        step(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, 32'h0);
        idle(2, 32'h300);
        step(0, 2'b10, 2'b10, 2'b01, 2'b00, 2'b01, 2'b01, 0, 32'h400);
        step(0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 0, 32'h400);
        // External stall during a branch request, then release
        idle(2, 32'h500);
        for (int i = 0; i < 3; i++)
            step(0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 1, 32'h600);
        step(0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 0, 32'h600);
        // Illegal code acts as load and sticks
        step(0, 2'b01, 2'b01, 2'b01, 2'b11, 2'b01, 2'b01, 0, 32'h700);
        idle(3, 32'h704);
        // Stall counter saturation
        step(1, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 0, 32'h0);
        for (int i = 0; i < CMAX + 3; i++)
            step(0, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 1, 32'h800);
        // Random traffic
        for (int i = 0; i < 500; i++) begin
            bit st = ($urandom_range(0, 5) == 0);
            bit rs = ($urandom_range(0, 59) == 0);
            step(rs, rcode(!st), rcode(!st), rcode(!st), rcode(!st),
                 ($urandom_range(0, 2) == 0) ? rcode(!st) : 2'b01,
                 ($urandom_range(0, 2) == 0) ? rcode(!st) : 2'b01,
                 st, $urandom);
        end

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        if (vectors == 0) begin
            miscompares++;
            $display("FAIL vectors: got 0 expected >0");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
